// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
//   Multi-issue instruction fetch stage with a decoupling bundle queue. Walks sequential
//   PCs, keeps at most one request outstanding on the imem port, and buffers ISSUE-wide
//   bundles for decode. A redirect flushes the queue and squashes any in-flight fetch.
// Ports
//   i_clk, i_rst_n        clock (rising edge), asynchronous active-low reset
//   i_redirect_valid/pc   restart fetch at a new word-aligned PC
//   o_imem_req/addr       fetch request; address held until granted
//   i_imem_gnt            request accepted this cycle
//   i_imem_rvalid/rdata   in-order response, slot i = word at addr + 4*i
//   o_out_valid/ready     head-of-queue handshake with decode
//   o_out_pc/instr        PC of slot 0 and the head bundle (slot 0 in bits [31:0])
module fetch_queue_unit #(
    parameter int unsigned ISSUE    = 2,
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_redirect_valid,
    input  logic [31:0]           i_redirect_pc,
    output logic                  o_imem_req,
    output logic [31:0]           o_imem_addr,
    input  logic                  i_imem_gnt,
    input  logic                  i_imem_rvalid,
    input  logic [32*ISSUE-1:0]   i_imem_rdata,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [31:0]           o_out_pc,
    output logic [32*ISSUE-1:0]   o_out_instr
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned IW    = 32 * ISSUE;
    localparam logic [31:0] STEP  = 32'(4 * ISSUE);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e             r_state;
    logic [31:0]        r_fetch_pc;
    logic [31:0]        r_req_pc;
    logic               r_drop;
    logic               r_imem_req;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [31:0]        r_mem_pc    [DEPTH];
    logic [IW-1:0]      r_mem_instr [DEPTH];

    logic               w_push;
    logic               w_pop;
    logic [CNT_W-1:0]   w_count_nxt;
    logic               w_space;

    always_comb begin
        w_push      = (r_state == StWait) && i_imem_rvalid && !r_drop;
        w_pop       = (r_count != '0) && i_out_ready;
        w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        // One slot must stay free for the bundle a new request will return.
        w_space     = w_count_nxt < CNT_W'(DEPTH);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= '0;
            r_drop     <= 1'b0;
            r_imem_req <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem_pc[i]    <= '0;
                r_mem_instr[i] <= '0;
            end
        end else if (i_redirect_valid) begin
            // Redirect overrides push, pop and the sequential PC step.
            r_fetch_pc <= i_redirect_pc;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            case (r_state)
                StIdle: begin
                    r_state    <= StReq;
                    r_imem_req <= 1'b1;
                end
                StReq: begin
                    if (i_imem_gnt) begin
                        // The request just granted carries the old PC.
                        r_drop     <= 1'b1;
                        r_state    <= StWait;
                        r_imem_req <= 1'b0;
                    end
                end
                StWait: begin
                    if (i_imem_rvalid) begin
                        r_drop     <= 1'b0;
                        r_state    <= StReq;
                        r_imem_req <= 1'b1;
                    end else begin
                        r_drop <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= StIdle;
                    r_imem_req <= 1'b0;
                end
            endcase
        end else begin
            if (w_push) begin
                r_mem_pc[r_wr_ptr]    <= r_req_pc;
                r_mem_instr[r_wr_ptr] <= i_imem_rdata;
                r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
            case (r_state)
                StIdle: begin
                    if (w_space) begin
                        r_state    <= StReq;
                        r_imem_req <= 1'b1;
                    end
                end
                StReq: begin
                    if (i_imem_gnt) begin
                        r_req_pc   <= r_fetch_pc;
                        r_fetch_pc <= r_fetch_pc + STEP;
                        r_state    <= StWait;
                        r_imem_req <= 1'b0;
                    end
                end
                StWait: begin
                    if (i_imem_rvalid) begin
                        r_drop     <= 1'b0;
                        r_state    <= w_space ? StReq : StIdle;
                        r_imem_req <= w_space;
                    end
                end
                default: begin
                    r_state    <= StIdle;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

    assign o_imem_req  = r_imem_req;
    assign o_imem_addr = r_fetch_pc;
    assign o_out_valid = (r_count != '0);
    assign o_out_pc    = r_mem_pc[r_rd_ptr];
    assign o_out_instr = r_mem_instr[r_rd_ptr];

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Scoreboard bench for fetch_queue_unit: ISSUE=2/DEPTH=4 main instance plus ISSUE=1 and
// ISSUE=4 instances for PC step and slot ordering. Inputs change 1 time unit after the
// rising edge; monitors sample on the falling edge.
module tb_fetch_queue_unit;

    typedef struct packed {
        logic [31:0]  pc;
        logic [127:0] ins;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic         rst_n = 1'b1;
    logic         redir_v = 1'b0;
    logic [31:0]  redir_pc = '0;
    logic         req, gnt = 1'b0, rvalid = 1'b0, ovalid, oready = 1'b0;
    logic [31:0]  addr, opc;
    logic [63:0]  rdata = '0, oinstr;

    // ISSUE=1 / ISSUE=4 instances
    logic         rst6_n = 1'b0;
    logic         req1, rv1 = 1'b0, ov1, req4, rv4 = 1'b0, ov4;
    logic [31:0]  addr1, addr4, opc1, opc4, rdata1 = '0, oi1;
    logic [127:0] rdata4 = '0, oi4;

    int           n_vec = 0, n_err = 0;
    int           n_resp, n_grants, pend_cnt, lat;
    logic [31:0]  pend_addr;
    logic         gnt_en, ready_follow;
    logic         pend1 = 1'b0, pend4 = 1'b0;
    logic [31:0]  pend_a1 = '0, pend_a4 = '0;
    logic [31:0]  gaddr[$];
    exp_t         sb[$], sb1[$], sb4[$];
    exp_t         m_e, m_e1, m_e4;

    fetch_queue_unit #(.ISSUE(2), .DEPTH(4), .RESET_PC(32'h0)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_redirect_valid(redir_v), .i_redirect_pc(redir_pc),
        .o_imem_req(req), .o_imem_addr(addr), .i_imem_gnt(gnt), .i_imem_rvalid(rvalid),
        .i_imem_rdata(rdata), .o_out_valid(ovalid), .i_out_ready(oready), .o_out_pc(opc),
        .o_out_instr(oinstr)
    );

    fetch_queue_unit #(.ISSUE(1), .DEPTH(4), .RESET_PC(32'h0)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst6_n), .i_redirect_valid(1'b0), .i_redirect_pc(32'h0),
        .o_imem_req(req1), .o_imem_addr(addr1), .i_imem_gnt(1'b1), .i_imem_rvalid(rv1),
        .i_imem_rdata(rdata1), .o_out_valid(ov1), .i_out_ready(1'b1), .o_out_pc(opc1),
        .o_out_instr(oi1)
    );

    fetch_queue_unit #(.ISSUE(4), .DEPTH(4), .RESET_PC(32'h0000_1000)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst6_n), .i_redirect_valid(1'b0), .i_redirect_pc(32'h0),
        .o_imem_req(req4), .o_imem_addr(addr4), .i_imem_gnt(1'b1), .i_imem_rvalid(rv4),
        .i_imem_rdata(rdata4), .o_out_valid(ov4), .i_out_ready(1'b1), .o_out_pc(opc4),
        .o_out_instr(oi4)
    );

    // memory content: word at address a
    function automatic logic [31:0] mk(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic logic [127:0] bundle(input logic [31:0] pc, input int n);
        logic [127:0] b = '0;
        for (int i = 0; i < n; i++) b[32*i +: 32] = mk(pc + 32'(4 * i));
        return b;
    endfunction

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic expect_seq(input logic [31:0] start, input int n);
        for (int k = 0; k < n; k++) sb.push_back({start + 32'(8 * k), bundle(start + 32'(8 * k), 2)});
    endtask

    // one cycle: advance past the edge, then play the memory side for this cycle
    task automatic tick();
        logic [127:0] tb;
        @(posedge clk);
        #1;
        redir_v = 1'b0;
        rvalid  = 1'b0;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                rvalid = 1'b1;
                tb     = bundle(pend_addr, 2);
                rdata  = tb[63:0];
                n_resp++;
            end
        end
        gnt = gnt_en;
        if (req && gnt) begin
            pend_cnt  = lat;
            pend_addr = addr;
            gaddr.push_back(addr);
            n_grants++;
        end
        if (ready_follow) oready = rvalid;
        rv1     = pend1;
        rdata1  = mk(pend_a1);
        pend1   = req1;
        pend_a1 = addr1;
        rv4     = pend4;
        rdata4  = bundle(pend_a4, 4);
        pend4   = req4;
        pend_a4 = addr4;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        oready = 1'b0; ready_follow = 1'b0; gnt_en = 1'b1; lat = 1;
        pend_cnt = 0; n_resp = 0; n_grants = 0;
        sb.delete(); gaddr.delete();
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    // kind 0: grant at address a; 1: response for a; 2: any request; 3: n_resp >= a
    task automatic wait_for(input int kind, input logic [31:0] a, input string name);
        bit hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            tick();
            case (kind)
                0: hit = req && gnt && addr == a;
                1: hit = rvalid && pend_addr == a;
                2: hit = req;
                default: hit = n_resp >= int'(a);
            endcase
        end
        if (!hit) timeout(name);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            timeout(name);
            sb.delete();
        end
        oready = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && ovalid && oready && !redir_v) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected bundle: got pc %0h, expected none", opc);
            end else begin
                m_e = sb.pop_front();
                chk("bundle", {opc, 64'h0, oinstr}, {m_e.pc, m_e.ins});
            end
        end
    end

    always @(negedge clk) begin
        if (rst6_n && ov1) begin
            if (sb1.size() == 0) timeout("issue1 unexpected bundle");
            else begin
                m_e1 = sb1.pop_front();
                chk("issue1 bundle", {opc1, 96'h0, oi1}, {m_e1.pc, m_e1.ins});
            end
        end
        if (rst6_n && ov4) begin
            if (sb4.size() == 0) timeout("issue4 unexpected bundle");
            else begin
                m_e4 = sb4.pop_front();
                chk("issue4 bundle", {opc4, oi4}, {m_e4.pc, m_e4.ins});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("reset out_valid", 160'(ovalid), 160'(0));
        chk("reset imem_req", 160'(req), 160'(0));
        chk("reset out_pc/instr", {opc, 64'h0, oinstr}, 160'(0));
        chk("reset imem_addr", 160'(addr), 160'(0));

        // 1: streaming with decode always ready
        do_reset();
        oready = 1'b1;
        expect_seq(32'h0, 5);
        drain("stream drain");
        chk("req addr 0", 160'(gaddr[0]), 160'(32'h0));
        chk("req addr 1", 160'(gaddr[1]), 160'(32'h8));
        chk("req addr 2", 160'(gaddr[2]), 160'(32'h10));

        // 2: decode stall fills exactly DEPTH bundles, then resumes in order
        do_reset();
        repeat (30) tick();
        chk("stall responses", 160'(n_resp), 160'(4));
        chk("stall grants", 160'(n_grants), 160'(4));
        chk("stall imem_req", 160'(req), 160'(0));
        chk("stall out_valid", 160'(ovalid), 160'(1));
        expect_seq(32'h0, 7);
        oready = 1'b1;
        drain("stall resume drain");

        // 3: redirect while waiting for the 0x10 response
        do_reset();
        lat = 3;
        wait_for(0, 32'h10, "grant 0x10");
        tick();
        redir_v = 1'b1; redir_pc = 32'h100;
        expect_seq(32'h100, 3);
        oready = 1'b1;
        drain("redirect in wait drain");

        // 4a: redirect in the same cycle as a grant
        do_reset();
        wait_for(0, 32'h8, "grant 0x8");
        redir_v = 1'b1; redir_pc = 32'h200;
        wait_for(2, 32'h0, "request after redirect");
        chk("addr after redirect+gnt", 160'(addr), 160'(32'h200));
        expect_seq(32'h200, 2);
        oready = 1'b1;
        drain("redirect gnt drain");

        // 4b: redirect in the same cycle as a response
        do_reset();
        wait_for(1, 32'h10, "response 0x10");
        redir_v = 1'b1; redir_pc = 32'h300;
        tick();
        chk("flush on rvalid", 160'(ovalid), 160'(0));
        expect_seq(32'h300, 2);
        oready = 1'b1;
        drain("redirect rvalid drain");

        // 5: push+pop together at DEPTH-1 across many wraps
        do_reset();
        expect_seq(32'h0, 15);
        wait_for(3, 32'd3, "three bundles");
        ready_follow = 1'b1;
        repeat (20) tick();
        chk("full at count 3", 160'(ovalid), 160'(1));
        ready_follow = 1'b0;
        oready = 1'b1;
        drain("wrap drain");

        // 5b: asynchronous reset in the middle of a wait
        do_reset();
        lat = 4;
        wait_for(0, 32'h10, "grant before reset");
        tick();
        chk("pre-reset out_valid", 160'(ovalid), 160'(1));
        chk("pre-reset out_pc", 160'(opc), 160'(32'h0));
        #2 rst_n = 1'b0;
        #1;
        pend_cnt = 0;
        chk("async reset out_valid", 160'(ovalid), 160'(0));
        chk("async reset imem_req", 160'(req), 160'(0));
        chk("async reset imem_addr", 160'(addr), 160'(0));
        tick();
        lat = 1;
        rst_n = 1'b1;
        wait_for(2, 32'h0, "request after reset");
        chk("first addr after reset", 160'(addr), 160'(32'h0));

        // 6: ISSUE=1 and ISSUE=4 builds
        for (int k = 0; k < 6; k++) begin
            sb1.push_back({32'(4 * k), bundle(32'(4 * k), 1)});
            sb4.push_back({32'h1000 + 32'(16 * k), bundle(32'h1000 + 32'(16 * k), 4)});
        end
        rst6_n = 1'b1;
        for (int i = 0; i < 100 && (sb1.size() != 0 || sb4.size() != 0); i++) tick();
        rst6_n = 1'b0;
        if (sb1.size() != 0) timeout("issue1 drain");
        if (sb4.size() != 0) timeout("issue4 drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
